pla_seq_eval: RTL and testbench
===============================

# pla_seq_eval

Sequential, programmable two-level (sum-of-products) logic evaluator: the run-time-loadable successor to our fixed, synthesised single-output PLA benchmark netlists. Cubes (input mask/value plus output plane) are written into an internal cube store. Input vectors are then streamed through a valid/ready handshake, and the block scans one cube per clock and returns the OR-plane result. It sits between the benchmark stimulus source and the result checker, so any PLA up to N_IN inputs, N_OUT outputs and N_CUBES cubes runs on one fabric instance.

## Interface
- N_IN, 10, number of PLA inputs
- N_OUT, 1, number of PLA outputs
- N_CUBES, 64, cube store depth
- EARLY_EXIT, 1, 1 = stop scanning once every output bit is already 1
- AW = max(1, clog2(N_CUBES)), CW = clog2(N_CUBES+1) (derived, not overridable)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  cube write strobe
- cfg_addr  in  AW  cube index
- cfg_mask  in  N_IN  1 = literal present, 0 = don't-care
- cfg_val  in  N_IN  required literal polarity (ignored where mask = 0)
- cfg_out  in  N_OUT  output-plane bits of the cube
- cfg_cnt_we  in  1  active-cube-count write strobe
- cfg_cnt  in  CW  number of active cubes (indices 0..cnt-1)
- cfg_err  out  1  one-cycle pulse: config write rejected
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_x  in  N_IN  input vector
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_y  out  N_OUT  evaluated outputs
- busy  out  1  high in SCAN or HOLD

## Operation
- Cube k matches x iff ((x ^ val[k]) & mask[k]) == 0. out_y = OR of cfg_out[k] over matching k < cnt.
- FSM states: IDLE, SCAN, HOLD.
  - IDLE: in_ready = 1. On in_valid, latch in_x, clear the accumulator and set idx = 0. Go to SCAN if cnt > 0, otherwise go to HOLD with out_y = 0.
  - SCAN: each cycle, evaluate cube idx and OR its output bits into the accumulator; then idx++.
    - Leave for HOLD after cube cnt-1 is evaluated.
    - If EARLY_EXIT = 1, also leave for HOLD after the cycle in which the accumulator becomes all-ones.
  - HOLD: out_valid = 1 and out_y = accumulator, held stable until out_ready. On out_valid & out_ready, go to IDLE.
- Config writes (cfg_we or cfg_cnt_we) are applied only in IDLE. Writes in SCAN or HOLD are dropped and cfg_err pulses the next cycle. A config write and an input accept in the same IDLE cycle are both honoured; the scan uses the new contents.
- cfg_cnt values above N_CUBES are clamped to N_CUBES.
- A write to cfg_addr ≥ N_CUBES (non-power-of-2 depth) is dropped with cfg_err.
- Cube store contents are not reset. The count register is reset, so stale cubes are never evaluated.

## Timing
- Reset values: state IDLE, cnt 0, in_ready 1, out_valid 0, out_y 0, busy 0, cfg_err 0.
- Accept at edge t:
  - With cnt = n > 0 and no early exit, out_valid is first high in cycle t+n+1.
  - With cnt = 0, out_valid is high in cycle t+1.
  - With early exit after cube j, out_valid is high in cycle t+j+2.
- in_ready is low from the accept edge until the cycle after the out handshake. Minimum period per vector is n+2 cycles.
- out_ready may be high before out_valid. The handshake completes in the first cycle both are high.
- rst asserted mid-SCAN or mid-HOLD: the transaction is aborted with no output and the block is in IDLE next cycle.
- cfg_err is registered: one cycle after the rejected strobe, one cycle wide.

## Test plan
- Reset, then read outputs -> in_ready = 1, out_valid = 0, out_y = 0, busy = 0; with cnt = 0, an input x = 0x3FF yields out_y = 0 and out_valid at t+1.
- N_IN = 10, N_OUT = 1, EARLY_EXIT = 0. Load cube0 mask 0x00C val 0x004, cube1 mask 0x300 val 0x300, cnt = 2. x = 0x004 -> y = 1 at t+3. x = 0x008 -> y = 0. x = 0x3FB -> y = 1 via cube1.
- EARLY_EXIT = 1, cnt = 8, cube0 all-don't-care with out = 1 -> out_valid at t+2, y = 1. The same cubes with EARLY_EXIT = 0 -> out_valid at t+9.
- Hold out_ready = 0 for 5 cycles in HOLD -> out_y stable, in_ready = 0, then a single transfer, and in_ready = 1 the next cycle.
- cfg_we during SCAN -> cube unchanged (rescan gives the old result), cfg_err pulses once. cfg_cnt = 100 with N_CUBES = 64 -> 64-cycle scan.
- rst asserted at t+2 of a 6-cube scan -> no out_valid, IDLE next cycle, cnt = 0. A subsequent vector returns y = 0.

Source files
------------

// File: rtl/pla_seq_eval.sv
// pla_seq_eval: run-time programmable sum-of-products evaluator.
// Cubes (mask/value/output plane) live in an unreset store; one cube is
// scanned per clock and its output bits are ORed into an accumulator.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in HOLD,
// where out_y is stable until out_ready is seen. out_ready may be high early.
module pla_seq_eval #(
    parameter int N_IN       = 10,
    parameter int N_OUT      = 1,
    parameter int N_CUBES    = 64,
    parameter int EARLY_EXIT = 1,
    localparam int AW = (N_CUBES > 1) ? $clog2(N_CUBES) : 1,
    localparam int CW = $clog2(N_CUBES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [N_IN-1:0]   cfg_mask,
    input  logic [N_IN-1:0]   cfg_val,
    input  logic [N_OUT-1:0]  cfg_out,
    input  logic              cfg_cnt_we,
    input  logic [CW-1:0]     cfg_cnt,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  out_y,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [CW-1:0] MAX_CNT = CW'(N_CUBES);
    localparam logic [AW:0]   DEPTH   = (AW + 1)'(N_CUBES);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_OUT-1:0] acc_q, acc_d;
    logic [N_IN-1:0]  x_q, x_d;
    logic             err_q, err_d;

    logic [N_IN-1:0]  mask_mem [N_CUBES];
    logic [N_IN-1:0]  val_mem  [N_CUBES];
    logic [N_OUT-1:0] out_mem  [N_CUBES];

    logic             idle;
    logic             addr_ok;
    logic             cube_wr;
    logic [CW-1:0]    cnt_clamped;
    logic [CW-1:0]    cnt_eff;
    logic [AW-1:0]    rd_idx;
    logic             cube_hit;
    logic [N_OUT-1:0] acc_scan;
    logic             last_cube;
    logic             ee_done;

    // Out-of-range addresses can only occur when the depth is not a power of two.
    generate
        if (N_CUBES == (1 << AW)) begin : g_addr_pow2
            assign addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign addr_ok = ({1'b0, cfg_addr} < DEPTH);
        end
    endgenerate

    assign idle        = (state_q == ST_IDLE);
    assign cube_wr     = idle & cfg_we & addr_ok;
    assign cnt_clamped = (cfg_cnt > MAX_CNT) ? MAX_CNT : cfg_cnt;
    // A count written in the accept cycle already governs that transaction.
    assign cnt_eff     = (idle & cfg_cnt_we) ? cnt_clamped : cnt_q;

    assign rd_idx    = idx_q[AW-1:0];
    assign cube_hit  = (((x_q ^ val_mem[rd_idx]) & mask_mem[rd_idx]) == '0);
    assign acc_scan  = acc_q | (cube_hit ? out_mem[rd_idx] : '0);
    assign last_cube = (idx_q == (cnt_q - CW'(1)));
    assign ee_done   = (EARLY_EXIT != 0) && (&acc_scan);

    // Cube store: written only while idle, never reset (count guards it).
    always_ff @(posedge clk) begin
        if (cube_wr) begin
            mask_mem[cfg_addr] <= cfg_mask;
            val_mem[cfg_addr]  <= cfg_val;
            out_mem[cfg_addr]  <= cfg_out;
        end
    end

    // Next-state logic for the IDLE/SCAN/HOLD controller and config handling.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        x_d     = x_q;
        cnt_d   = (idle & cfg_cnt_we) ? cnt_clamped : cnt_q;
        err_d   = ((cfg_we | cfg_cnt_we) & ~idle) | (cfg_we & idle & ~addr_ok);
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d     = in_x;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = (cnt_eff != '0) ? ST_SCAN : ST_HOLD;
                end
            end
            ST_SCAN: begin
                acc_d = acc_scan;
                idx_d = idx_q + CW'(1);
                if (last_cube || ee_done) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = idle;
    assign out_valid = (state_q == ST_HOLD);
    assign out_y     = acc_q;
    assign busy      = ~idle;
    assign cfg_err   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pla_seq_eval.sv
// Directed bench for pla_seq_eval: two instances (early exit off / on) share
// the config bus; expected results are queued at accept and popped at output.
module tb_pla_seq_eval;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [5:0] cfg_addr;
    logic [9:0] cfg_mask;
    logic [9:0] cfg_val;
    logic [0:0] cfg_out;
    logic       cfg_cnt_we;
    logic [6:0] cfg_cnt;
    logic [9:0] in_x;
    logic       in_valid, in_valid_e;
    logic       out_ready, out_ready_e;
    logic       cfg_err, cfg_err_e;
    logic       in_ready, in_ready_e;
    logic       out_valid, out_valid_e;
    logic [0:0] out_y, out_y_e;
    logic       busy, busy_e;
    logic [1:0] dbg_state, dbg_state_e;

    logic [0:0] exp_q[$];
    logic [9:0] m_mask [64];
    logic [9:0] m_val  [64];
    logic [0:0] m_out  [64];
    int         m_cnt;
    logic [0:0] last_exp;
    int         n_cmp = 0;
    int         n_fail = 0;

    pla_seq_eval #(.N_IN(10), .N_OUT(1), .N_CUBES(64), .EARLY_EXIT(0)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_mask(cfg_mask), .cfg_val(cfg_val), .cfg_out(cfg_out),
        .cfg_cnt_we(cfg_cnt_we), .cfg_cnt(cfg_cnt), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .busy(busy), .dbg_state(dbg_state)
    );

    pla_seq_eval #(.N_IN(10), .N_OUT(1), .N_CUBES(64), .EARLY_EXIT(1)) dut_ee (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_mask(cfg_mask), .cfg_val(cfg_val), .cfg_out(cfg_out),
        .cfg_cnt_we(cfg_cnt_we), .cfg_cnt(cfg_cnt), .cfg_err(cfg_err_e),
        .in_valid(in_valid_e), .in_ready(in_ready_e), .in_x(in_x),
        .out_valid(out_valid_e), .out_ready(out_ready_e), .out_y(out_y_e),
        .busy(busy_e), .dbg_state(dbg_state_e)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:0] model_eval(input logic [9:0] x);
        logic [0:0] y;
        y = 1'b0;
        for (int k = 0; k < m_cnt; k++) begin
            if (((x ^ m_val[k]) & m_mask[k]) == 10'h000) y = y | m_out[k];
        end
        return y;
    endfunction

    // Driver tasks start and end just after a rising edge.
    task automatic write_cube(input int a, input logic [9:0] mk, input logic [9:0] vl, input logic [0:0] o);
        cfg_we   = 1'b1;
        cfg_addr = 6'(a);
        cfg_mask = mk;
        cfg_val  = vl;
        cfg_out  = o;
        m_mask[a] = mk;
        m_val[a]  = vl;
        m_out[a]  = o;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic write_cnt(input int n);
        cfg_cnt_we = 1'b1;
        cfg_cnt    = 7'(n);
        m_cnt      = (n > 64) ? 64 : n;
        @(posedge clk); #1;
        cfg_cnt_we = 1'b0;
    endtask

    task automatic accept(input int which, input logic [9:0] x, input logic [0:0] e);
        in_x = x;
        if (which == 0) in_valid = 1'b1; else in_valid_e = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        chk("in_ready_before_accept", 32'(which == 0 ? in_ready : in_ready_e), 32'd1);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_valid_e = 1'b0;
        cfg_cnt_we = 1'b0;
    endtask

    task automatic wait_out(input int which, input int exp_lat, input string tag);
        int c;
        logic ov;
        logic [0:0] oy;
        logic [0:0] e;
        c  = 0;
        ov = 1'b0;
        oy = 1'b0;
        while (!ov && c < 300) begin
            @(negedge clk);
            c++;
            ov = (which == 0) ? out_valid : out_valid_e;
            oy = (which == 0) ? out_y : out_y_e;
        end
        if (!ov) begin
            chk({tag, "_timeout"}, 32'(ov), 32'd1);
            return;
        end
        if (exp_lat > 0) chk({tag, "_latency"}, 32'(c), 32'(exp_lat));
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        last_exp = e;
        chk({tag, "_y"}, 32'(oy), 32'(e));
    endtask

    task automatic send_vec(input int which, input logic [9:0] x, input logic [0:0] e,
                            input int exp_lat, input string tag);
        accept(which, x, e);
        wait_out(which, exp_lat, tag);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [9:0] x;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_mask = '0; cfg_val = '0;
        cfg_out = '0; cfg_cnt_we = 1'b0; cfg_cnt = '0; in_x = '0;
        in_valid = 1'b0; in_valid_e = 1'b0; out_ready = 1'b1; out_ready_e = 1'b1;
        m_cnt = 0; last_exp = 1'b0;
        for (int k = 0; k < 64; k++) begin
            m_mask[k] = '0; m_val[k] = '0; m_out[k] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_ee_idle", 32'({busy_e, out_valid_e, cfg_err_e, dbg_state_e, in_ready_e}), 32'd1);
        @(posedge clk); #1;

        // Empty PLA: immediate zero result
        send_vec(0, 10'h3FF, 1'b0, 1, "cnt0");

        // Fill the whole store so any count sees defined cubes
        for (int k = 0; k < 64; k++) begin
            write_cube(k, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                       1'($urandom_range(0, 1)));
        end

        // Two-cube function
        write_cube(0, 10'h00C, 10'h004, 1'b1);
        write_cube(1, 10'h300, 10'h300, 1'b1);
        write_cnt(2);
        send_vec(0, 10'h004, 1'b1, 3, "cube0_hit");
        send_vec(0, 10'h008, 1'b0, 3, "no_hit");
        send_vec(0, 10'h3FB, 1'b1, 3, "cube1_hit");

        // Count write in the accept cycle governs that scan
        cfg_cnt_we = 1'b1;
        cfg_cnt    = 7'd0;
        m_cnt      = 0;
        send_vec(0, 10'h004, 1'b0, 1, "same_cycle_cnt");

        // Early exit on an all-don't-care cube 0
        write_cube(0, 10'h000, 10'h000, 1'b1);
        write_cnt(8);
        x = 10'($urandom_range(0, 1023));
        send_vec(0, x, 1'b1, 9, "full_scan8");
        send_vec(1, x, 1'b1, 2, "ee_cube0");

        // Early exit after cube 3
        write_cube(0, 10'h3FF, 10'h000, 1'b1);
        write_cube(1, 10'h3FF, 10'h000, 1'b1);
        write_cube(2, 10'h3FF, 10'h000, 1'b1);
        write_cube(3, 10'h3FF, 10'h155, 1'b1);
        send_vec(1, 10'h155, 1'b1, 5, "ee_cube3");
        send_vec(0, 10'h155, 1'b1, 9, "noee_cube3");

        // Config write during SCAN is dropped and flagged
        write_cnt(4);
        accept(0, 10'h155, 1'b1);
        cfg_we = 1'b1; cfg_addr = 6'd3; cfg_mask = 10'h3FF; cfg_val = 10'h000; cfg_out = 1'b0;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(negedge clk);
        chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("cfg_err_single", 32'(cfg_err), 32'd0);
        wait_out(0, -1, "scan_with_drop");
        @(posedge clk); #1;
        send_vec(0, 10'h155, 1'b1, 5, "rescan_old_cube");

        // Count clamp to full depth
        write_cnt(100);
        for (int i = 0; i < 2; i++) begin
            x = 10'($urandom_range(0, 1023));
            send_vec(0, x, model_eval(x), 65, "clamp64");
        end

        // Back-pressure in HOLD
        write_cnt(2);
        out_ready = 1'b0;
        x = 10'($urandom_range(0, 1023));
        accept(0, x, model_eval(x));
        wait_out(0, 3, "hold");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_y_stable", 32'(out_y), 32'(last_exp));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_valid_at_hs", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("after_hs_valid", 32'(out_valid), 32'd0);
        chk("after_hs_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Reset mid-scan aborts and clears the count
        write_cnt(6);
        accept(0, 10'h155, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        m_cnt = 0;
        @(negedge clk);
        chk("abort_state", 32'(dbg_state), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send_vec(0, 10'h155, 1'b0, 1, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
